// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and synchronous flush.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 16,
  parameter int NCH    = 3,
  parameter int RD_W   = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic                  in_zero,
  input  logic [RD_W-1:0]       in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic                  out_zero,
  output logic [RD_W-1:0]       out_rd,
  output logic [1:0]            occupancy
);

  localparam int EW = CTRL_W + NCH*DATA_W + 1 + RD_W;

  logic [EW-1:0] in_ent;
  logic [EW-1:0] head_q, head_d;
  logic          push, pop;

  assign in_ent = {in_ctrl, in_data, in_zero, in_rd};

`ifdef PIPE_STAGE_SKID_EN
  logic [EW-1:0] tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          rdy_q, rdy_d;

  assign push = in_valid && rdy_q;
  assign pop  = (cnt_q != 2'd0) && out_ready;

  // Head refills from the tail on a pop at full, or directly from the input
  // when the incoming entry would otherwise land at the front.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      if (pop && cnt_q == 2'd2)
        head_d = tail_q;
      else if (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)))
        head_d = in_ent;
      if (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop)))
        tail_d = in_ent;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b1;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (cnt_q != 2'd0);
  assign occupancy = cnt_q;
`else
  logic valid_q, valid_d;

  assign in_ready = out_ready || !valid_q;
  assign push     = in_valid && in_ready;
  assign pop      = valid_q && out_ready;

  always_comb begin
    head_d  = head_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (push) begin
      head_d  = in_ent;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign occupancy = {1'b0, valid_q};
`endif

  // Bubbles carry no control, zero flag or destination; data keeps its last value.
  assign out_ctrl = out_valid ? head_q[EW-1 -: CTRL_W] : '0;
  assign out_data = head_q[RD_W+1 +: NCH*DATA_W];
  assign out_zero = out_valid ? head_q[RD_W] : 1'b0;
  assign out_rd   = out_valid ? head_q[RD_W-1:0] : '0;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 8, width of the control bundle (writeSpecReg, memtoReg, regWrite, memRead, memWrite, branch).
REQ-002 SHALL have parameter DATA_W, default 16, width of one data channel.
REQ-003 SHALL have parameter NCH, default 3, number of data channels (PC, ALU result, store data).
REQ-004 SHALL have parameter RD_W, default 3, destination-register-id width.
REQ-005 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port RST_N  input  1  asynchronous reset, active-low.
REQ-007 SHALL have port flush  input  1  synchronous squash of all held entries.
REQ-008 SHALL have port in_valid  input  1  upstream entry present.
REQ-009 SHALL have port in_ready  output  1  stage accepts an entry this cycle.
REQ-010 SHALL have port in_ctrl  input  CTRL_W  control bundle.
REQ-011 SHALL have port in_data  input  NCH*DATA_W  data channels; channel k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port in_zero  input  1  ALU zero flag.
REQ-013 SHALL have port in_rd  input  RD_W  destination register id.
REQ-014 SHALL have port out_valid  output  1  head entry present.
REQ-015 SHALL have port out_ready  input  1  downstream consumes the head entry.
REQ-016 SHALL have ports out_ctrl, out_data, out_zero, out_rd  output  same widths as inputs  head entry fields.
REQ-017 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-018 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready; both are evaluated at the same rising edge.
REQ-019 An accepted entry SHALL appear on the out_* ports exactly 1 cycle after acceptance when the stage was empty; order SHALL be strictly FIFO.
REQ-020 out_ctrl, out_zero and out_rd SHALL be forced to 0 whenever out_valid=0 (bubble carries no register or memory writes); out_data SHALL hold its last value.
REQ-021 On simultaneous push and pop, occupancy SHALL be unchanged, and the pushed entry SHALL become the tail (or the head if occupancy was 1).
REQ-022 A pop with in_valid=0 SHALL decrement occupancy; a push without a pop SHALL increment it; occupancy SHALL never exceed its mode maximum or underflow.
REQ-023 flush=1 SHALL, at the next edge, set occupancy=0 and out_valid=0 and discard any entry pushed in that cycle; flush SHALL take priority over push and pop.
REQ-024 in_ready and out_valid SHALL NOT depend combinationally on in_valid.

Reset
REQ-025 While RST_N=0: occupancy=0, out_valid=0, out_ctrl=0, out_zero=0, out_rd=0, out_data=0, and in_ready=1.
REQ-026 Reset asserted mid-transfer SHALL drop all entries immediately, without waiting for CLK.
REQ-027 The first push SHALL be accepted at the first rising edge after RST_N deasserts.

Configuration
REQ-028 With macro PIPE_STAGE_SKID_EN defined, the stage SHALL be a 2-entry skid buffer: in_ready is a registered signal equal to (occupancy<2), occupancy ranges 0..2, and there is no combinational path from out_ready to in_ready.
REQ-029 Without PIPE_STAGE_SKID_EN, the stage SHALL hold 1 entry: in_ready = out_ready || !out_valid (combinational), occupancy ranges 0..1, and throughput is 1 entry per cycle with out_ready held at 1.

Verification
REQ-030 Reset, then in_valid=1 with in_ctrl=0x5A, in_data={0x1234,0xBEEF,0x0042}, in_rd=5 and out_ready=1 -> one cycle later out_valid=1 with the same values; occupancy=1.
REQ-031 Skid mode: out_ready=0, push 3 entries A, B, C -> A and B accepted, occupancy=2, in_ready=0, C held; out_ready=1 -> A, B, C leave in order on consecutive cycles.
REQ-032 Non-skid mode: out_ready=0 with 1 entry held -> in_ready=0; raise out_ready in the same cycle as in_valid -> pop and push both occur, occupancy stays 1.
REQ-033 With occupancy=2, assert flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, out_rd=0, and the new entry is not delivered.
REQ-034 Drop RST_N asynchronously between edges with occupancy=1 -> out_valid=0 and occupancy=0 before the next CLK edge.
REQ-035 Continuous stream of 100 entries with out_ready=1 -> 100 entries delivered in order, zero bubbles after the first, in both configurations.
